// File: rtl/vending_machine_param_if.sv
// Front-end bundle for the vending controller: keypad, card reader, bank and door
// inputs toward the controller, registered status outputs back to the front end.
interface vending_machine_param_if #(
    parameter int COST_W = 3
);
    // Level inputs are sampled on every rising clock edge. Strobes act on their rising
    // edge. Every output is registered. Pulse outputs are high for exactly one cycle.
    logic              i_reload;
    logic              i_card_in;
    logic [3:0]        i_item_code;
    logic              i_key_press;
    logic              i_valid_tran;
    logic              i_door_open;
    logic              o_vend;
    logic              o_invalid_sel;
    logic              o_sold_out;
    logic [COST_W-1:0] o_cost;
    logic              o_failed_tran;
    logic [2:0]        o_dbg_state;

    modport master (
        output i_reload, i_card_in, i_item_code, i_key_press, i_valid_tran, i_door_open,
        input  o_vend, o_invalid_sel, o_sold_out, o_cost, o_failed_tran, o_dbg_state
    );

    modport slave (
        input  i_reload, i_card_in, i_item_code, i_key_press, i_valid_tran, i_door_open,
        output o_vend, o_invalid_sel, o_sold_out, o_cost, o_failed_tran, o_dbg_state
    );
endinterface

// File: rtl/vending_machine_param.sv
// Card-operated vending controller: two-digit item entry, per-slot stock,
// tiered pricing, per-state timeouts, abort on card removal.
module vending_machine_param #(
    parameter int NUM_ITEMS      = 20,
    parameter int STOCK_MAX      = 10,
    parameter int ITEMS_PER_TIER = 4,
    parameter int COST_W         = 3,
    parameter int TIMEOUT        = 5
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    vending_machine_param_if.slave bus
);
    localparam int STOCK_W  = $clog2(STOCK_MAX + 1);
    localparam int TMR_W    = $clog2(TIMEOUT + 1);
    localparam int IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int COST_MAX = (1 << COST_W) - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_GET_D1, S_GET_D2, S_CHECK, S_WAIT_TRAN, S_WAIT_OPEN, S_WAIT_CLOSE
    } state_t;

    state_t             r_state, w_next_state;
    logic [TMR_W-1:0]   r_timer;
    logic               r_card_d, r_key_d;
    logic [3:0]         r_d1, r_d2;
    logic [IDX_W-1:0]   r_sel;
    logic [STOCK_W-1:0] r_stock [NUM_ITEMS];
    logic               r_vend, r_invalid, r_sold_out, r_failed;
    logic [COST_W-1:0]  r_cost;

    logic               w_card_rise, w_key_rise, w_timeout, w_abort, w_code_ok;
    logic [7:0]         w_code, w_tier;
    logic [IDX_W-1:0]   w_idx;
    logic [COST_W-1:0]  w_cost, w_cost_nxt;
    logic               w_vend, w_invalid, w_sold_out, w_failed;
    logic               w_ld1, w_ld2, w_reload, w_dec, w_ld_sel;

    assign w_card_rise = bus.i_card_in & ~r_card_d;
    assign w_key_rise  = bus.i_key_press & ~r_key_d;
    assign w_timeout   = (r_timer == TMR_W'(TIMEOUT - 1));
    assign w_abort     = ~bus.i_card_in;

    // Digits above 9 make the code invalid even if the arithmetic lands in range.
    assign w_code    = 8'(r_d1) * 8'd10 + 8'(r_d2);
    assign w_code_ok = (r_d1 <= 4'd9) && (r_d2 <= 4'd9) && (w_code < 8'(NUM_ITEMS));
    assign w_idx     = w_code_ok ? w_code[IDX_W-1:0] : '0;
    assign w_tier    = 8'd1 + (w_code / 8'(ITEMS_PER_TIER));
    assign w_cost    = (w_tier > 8'(COST_MAX)) ? COST_W'(COST_MAX) : w_tier[COST_W-1:0];

    always_comb begin
        w_next_state = r_state;
        w_cost_nxt   = r_cost;
        w_vend       = r_vend;
        w_invalid    = 1'b0;
        w_sold_out   = 1'b0;
        w_failed     = 1'b0;
        w_ld1        = 1'b0;
        w_ld2        = 1'b0;
        w_reload     = 1'b0;
        w_dec        = 1'b0;
        w_ld_sel     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_reload)     w_reload = 1'b1;
                else if (w_card_rise) w_next_state = S_GET_D1;
            end
            S_GET_D1: begin
                if (w_abort) w_next_state = S_IDLE;
                else if (w_key_rise) begin
                    w_ld1        = 1'b1;
                    w_next_state = S_GET_D2;
                end else if (w_timeout) w_next_state = S_IDLE;
            end
            S_GET_D2: begin
                if (w_abort) w_next_state = S_IDLE;
                else if (w_key_rise) begin
                    w_ld2        = 1'b1;
                    w_next_state = S_CHECK;
                end else if (w_timeout) begin
                    w_invalid    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_CHECK: begin
                w_next_state = S_IDLE;
                if (w_abort) begin
                    w_next_state = S_IDLE;
                end else if (!w_code_ok) begin
                    w_invalid = 1'b1;
                end else if (r_stock[w_idx] == '0) begin
                    w_invalid  = 1'b1;
                    w_sold_out = 1'b1;
                end else begin
                    w_cost_nxt   = w_cost;
                    w_ld_sel     = 1'b1;
                    w_next_state = S_WAIT_TRAN;
                end
            end
            S_WAIT_TRAN: begin
                if (w_abort) begin
                    w_cost_nxt   = '0;
                    w_next_state = S_IDLE;
                end else if (bus.i_valid_tran) begin
                    w_dec        = 1'b1;
                    w_vend       = 1'b1;
                    w_next_state = S_WAIT_OPEN;
                end else if (w_timeout) begin
                    w_failed     = 1'b1;
                    w_cost_nxt   = '0;
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_OPEN: begin
                if (bus.i_door_open) begin
                    w_vend       = 1'b0;
                    w_next_state = S_WAIT_CLOSE;
                end else if (w_timeout) begin
                    w_vend       = 1'b0;
                    w_cost_nxt   = '0;
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_CLOSE: begin
                if (!bus.i_door_open) begin
                    w_cost_nxt   = '0;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_card_d   <= 1'b0;
            r_key_d    <= 1'b0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_sel      <= '0;
            r_vend     <= 1'b0;
            r_invalid  <= 1'b0;
            r_sold_out <= 1'b0;
            r_failed   <= 1'b0;
            r_cost     <= '0;
        end else begin
            r_state    <= w_next_state;
            r_card_d   <= bus.i_card_in;
            r_key_d    <= bus.i_key_press;
            r_vend     <= w_vend;
            r_invalid  <= w_invalid;
            r_sold_out <= w_sold_out;
            r_failed   <= w_failed;
            r_cost     <= w_cost_nxt;
            if (w_ld1)    r_d1  <= bus.i_item_code;
            if (w_ld2)    r_d2  <= bus.i_item_code;
            if (w_ld_sel) r_sel <= w_idx;
            // Timer restarts on every state change so each wait gets a full window.
            if (w_next_state != r_state) r_timer <= '0;
            else if (!w_timeout)         r_timer <= r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= '0;
        end else if (w_reload) begin
            for (int i = 0; i < NUM_ITEMS; i++) r_stock[i] <= STOCK_W'(STOCK_MAX);
        end else if (w_dec && (r_stock[r_sel] != '0)) begin
            r_stock[r_sel] <= r_stock[r_sel] - STOCK_W'(1);
        end
    end

    assign bus.o_vend        = r_vend;
    assign bus.o_invalid_sel = r_invalid;
    assign bus.o_sold_out    = r_sold_out;
    assign bus.o_cost        = r_cost;
    assign bus.o_failed_tran = r_failed;
    assign bus.o_dbg_state   = r_state;
endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: directed scenarios plus randomized transactions
// predicted by a transaction-level model of slot stock and pricing.
module tb_vending_machine_param;
    localparam int NUM_ITEMS      = 20;
    localparam int STOCK_MAX      = 10;
    localparam int ITEMS_PER_TIER = 4;
    localparam int COST_W         = 3;
    localparam int TIMEOUT        = 5;
    localparam int COST_MAX       = (1 << COST_W) - 1;
    localparam int OUT_W          = COST_W + 2;
    localparam int ST_IDLE = 0, ST_GET_D1 = 1, ST_GET_D2 = 2;
    localparam int ST_WAIT_OPEN = 5, ST_WAIT_CLOSE = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vending_machine_param_if #(.COST_W(COST_W)) vm_if ();

    vending_machine_param #(
        .NUM_ITEMS(NUM_ITEMS), .STOCK_MAX(STOCK_MAX), .ITEMS_PER_TIER(ITEMS_PER_TIER),
        .COST_W(COST_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (vm_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_stock [NUM_ITEMS];
    logic [OUT_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_fill(input int v);
        for (int i = 0; i < NUM_ITEMS; i++) m_stock[i] = v;
    endtask

    task automatic press_key(input int d);
        vm_if.i_item_code = 4'(d);
        vm_if.i_key_press = 1'b1;
        tick();
        vm_if.i_key_press = 1'b0;
        tick();
    endtask

    task automatic leave_card();
        vm_if.i_card_in = 1'b0;
        tick();
        check_eq("idle_after_txn", vm_if.o_dbg_state, ST_IDLE);
        check_eq("cost_idle", vm_if.o_cost, 0);
    endtask

    // dig_mode: 0 normal, 1 no first digit, 2 no second digit, 3 card pulled after digit 1
    // tran_mode: 0 approve after tran_wait idle cycles, 1 never approve, 2 card pulled
    // door_mode: 0 open after door_wait cycles, 1 never open
    task automatic run_txn(input int d1, input int d2, input int dig_mode, input int tran_mode,
                           input int tran_wait, input int door_mode, input int door_wait);
        int  code;
        bit  ok;
        bit  sold;
        int  cost;
        code = 10 * d1 + d2;
        vm_if.i_card_in = 1'b1;
        tick();
        check_eq("card_rise", vm_if.o_dbg_state, ST_GET_D1);
        if (dig_mode == 1) begin
            repeat (TIMEOUT - 1) tick();
            check_eq("d1_wait", vm_if.o_dbg_state, ST_GET_D1);
            tick();
            check_eq("d1_timeout_state", vm_if.o_dbg_state, ST_IDLE);
            check_eq("d1_timeout_no_inv", vm_if.o_invalid_sel, 0);
            repeat (2) tick();
            check_eq("card_left_in", vm_if.o_dbg_state, ST_IDLE);
            leave_card();
            return;
        end
        press_key(d1);
        check_eq("d1_taken", vm_if.o_dbg_state, ST_GET_D2);
        if (dig_mode == 3) begin
            vm_if.i_card_in = 1'b0;
            tick();
            check_eq("abort_d2_state", vm_if.o_dbg_state, ST_IDLE);
            check_eq("abort_d2_inv", vm_if.o_invalid_sel, 0);
            return;
        end
        if (dig_mode == 2) begin
            repeat (TIMEOUT - 2) tick();
            check_eq("d2_wait_inv", vm_if.o_invalid_sel, 0);
            tick();
            check_eq("d2_timeout_inv", vm_if.o_invalid_sel, 1);
            check_eq("d2_timeout_state", vm_if.o_dbg_state, ST_IDLE);
            tick();
            check_eq("d2_inv_pulse_end", vm_if.o_invalid_sel, 0);
            leave_card();
            return;
        end
        press_key(d2);
        ok   = (d1 <= 9) && (d2 <= 9) && (code < NUM_ITEMS);
        sold = ok && (m_stock[code] == 0);
        cost = (ok && !sold) ? ((1 + code / ITEMS_PER_TIER > COST_MAX) ? COST_MAX
                                                                     : 1 + code / ITEMS_PER_TIER) : 0;
        exp_q.push_back({(!ok || sold), sold, COST_W'(cost)});
        check_eq("select_outcome", {vm_if.o_invalid_sel, vm_if.o_sold_out, vm_if.o_cost},
                 exp_q.pop_front());
        if (!ok || sold) begin
            tick();
            check_eq("inv_pulse_end", {vm_if.o_invalid_sel, vm_if.o_sold_out}, 0);
            leave_card();
            return;
        end
        if (tran_mode == 2) begin
            vm_if.i_card_in = 1'b0;
            tick();
            check_eq("abort_tran_state", vm_if.o_dbg_state, ST_IDLE);
            check_eq("abort_tran_pulses",
                     {vm_if.o_vend, vm_if.o_failed_tran, vm_if.o_invalid_sel}, 0);
            check_eq("abort_tran_cost", vm_if.o_cost, 0);
            return;
        end
        if (tran_mode == 1) begin
            repeat (TIMEOUT - 1) tick();
            check_eq("tran_wait_nofail", vm_if.o_failed_tran, 0);
            tick();
            check_eq("tran_timeout_fail", vm_if.o_failed_tran, 1);
            check_eq("tran_timeout_cost", vm_if.o_cost, 0);
            tick();
            check_eq("fail_pulse_end", vm_if.o_failed_tran, 0);
            leave_card();
            return;
        end
        repeat (tran_wait) tick();
        vm_if.i_valid_tran = 1'b1;
        tick();
        vm_if.i_valid_tran = 1'b0;
        m_stock[code] = m_stock[code] - 1;
        check_eq("vend_on", vm_if.o_vend, 1);
        check_eq("vend_state", vm_if.o_dbg_state, ST_WAIT_OPEN);
        if (door_mode == 1) begin
            repeat (TIMEOUT - 1) tick();
            check_eq("vend_held", vm_if.o_vend, 1);
            tick();
            check_eq("door_timeout_vend", vm_if.o_vend, 0);
            check_eq("door_timeout_state", vm_if.o_dbg_state, ST_IDLE);
            leave_card();
            return;
        end
        repeat (door_wait) tick();
        check_eq("vend_until_door", vm_if.o_vend, 1);
        vm_if.i_door_open = 1'b1;
        vm_if.i_card_in   = 1'b0;
        tick();
        check_eq("door_open_vend", vm_if.o_vend, 0);
        check_eq("door_open_cost", vm_if.o_cost, cost);
        tick();
        check_eq("wait_close_state", vm_if.o_dbg_state, ST_WAIT_CLOSE);
        vm_if.i_door_open = 1'b0;
        leave_card();
    endtask

    initial begin
        vm_if.i_reload     = 1'b0;
        vm_if.i_card_in    = 1'b0;
        vm_if.i_item_code  = 4'd0;
        vm_if.i_key_press  = 1'b0;
        vm_if.i_valid_tran = 1'b0;
        vm_if.i_door_open  = 1'b0;
        model_fill(0);
        repeat (2) tick();
        check_eq("reset_outputs", {vm_if.o_vend, vm_if.o_invalid_sel, vm_if.o_sold_out,
                                   vm_if.o_cost, vm_if.o_failed_tran}, 0);
        check_eq("reset_state", vm_if.o_dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        run_txn(0, 5, 0, 0, 0, 0, 0);
        vm_if.i_key_press = 1'b1;
        tick();
        vm_if.i_key_press = 1'b0;
        tick();
        check_eq("key_in_idle", vm_if.o_dbg_state, ST_IDLE);

        vm_if.i_reload  = 1'b1;
        vm_if.i_card_in = 1'b1;
        tick();
        model_fill(STOCK_MAX);
        vm_if.i_reload = 1'b0;
        check_eq("reload_priority", vm_if.o_dbg_state, ST_IDLE);
        repeat (2) tick();
        check_eq("reload_card_held", vm_if.o_dbg_state, ST_IDLE);
        vm_if.i_card_in = 1'b0;
        tick();

        run_txn(1, 3, 0, 0, 1, 0, 2);
        run_txn(1, 3, 1, 0, 0, 0, 0);
        run_txn(0, 1, 0, 0, 0, 0, 0);
        run_txn(2, 7, 0, 0, 0, 0, 0);
        run_txn(1, 0, 2, 0, 0, 0, 0);
        run_txn(0, 7, 0, 1, 0, 0, 0);
        run_txn(0, 7, 0, 0, TIMEOUT - 1, 0, TIMEOUT - 1);
        run_txn(1, 9, 0, 0, 0, 1, 0);
        run_txn(0, 3, 0, 2, 0, 0, 0);
        run_txn(0, 4, 3, 0, 0, 0, 0);
        run_txn(2, 0, 0, 0, 0, 0, 0);
        run_txn(10, 1, 0, 0, 0, 0, 0);
        run_txn(0, 12, 0, 0, 0, 0, 0);
        repeat (10) run_txn(0, 5, 0, 0, $urandom_range(0, TIMEOUT - 1), 0, $urandom_range(0, 3));
        run_txn(0, 5, 0, 0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            int d1, d2, dm, tm;
            if ($urandom_range(0, 5) == 0) begin
                vm_if.i_reload = 1'b1;
                tick();
                vm_if.i_reload = 1'b0;
                model_fill(STOCK_MAX);
            end
            d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 2);
            d2 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            dm = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
            tm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            run_txn(d1, d2, dm, tm, $urandom_range(0, TIMEOUT - 1),
                    ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(0, TIMEOUT - 1));
            repeat ($urandom_range(0, 2)) tick();
        end

        vm_if.i_reload = 1'b1;
        tick();
        vm_if.i_reload = 1'b0;
        vm_if.i_card_in = 1'b1;
        tick();
        press_key(1);
        press_key(3);
        vm_if.i_valid_tran = 1'b1;
        tick();
        vm_if.i_valid_tran = 1'b0;
        check_eq("pre_reset_vend", vm_if.o_vend, 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_vend", vm_if.o_vend, 0);
        check_eq("async_reset_state", vm_if.o_dbg_state, ST_IDLE);
        model_fill(0);
        vm_if.i_card_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(1, 3, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
